spi_flash_responder: RTL

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI slave with a small byte memory: handles WREN/WRDI/WRITE/READ/RDSR on an oversampled SPI port.
// Acts about 3 clk after each sclk/cs edge (2-flop sync + edge detect); no backpressure, the master sets the pace.
module spi_flash_responder #(
  parameter int MEM_AW = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  input  logic              cpol_i,
  input  logic              cpha_i,
  output logic              miso,
  output logic              wr_stb,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cmd_err,
  output logic              wel,
  output logic              active
);

  typedef enum logic [3:0] {
    IDLE, INSTR, ADDR1, ADDR2, ADDR3, WDATA, RDATA, STAT, IGNORE
  } state_t;

  state_t            state;
  logic [1:0]        sclk_sync, cs_sync, mosi_sync;
  logic              sclk_q, cs_q;
  logic [1:0]        warm;
  logic              armed;
  logic              cpol_r, cpha_r;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sr;
  logic [7:0]        tx_sr;
  logic [MEM_AW-1:0] ptr;
  logic              op_read;
  logic              wrote;
  logic [7:0]        mem [2**MEM_AW];

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic       cs_rise, cs_fall, byte_done, mem_we;
  logic [7:0] rx_byte;

  always_comb begin
    sclk_s      = sclk_sync[1];
    cs_s        = cs_sync[1];
    mosi_s      = mosi_sync[1];
    sclk_rise   = sclk_s & ~sclk_q;
    sclk_fall   = ~sclk_s & sclk_q;
    lead_edge   = cpol_r ? sclk_fall : sclk_rise;
    trail_edge  = cpol_r ? sclk_rise : sclk_fall;
    sample_edge = cpha_r ? trail_edge : lead_edge;
    shift_edge  = cpha_r ? lead_edge : trail_edge;
    // A rise only counts once cs has been seen low after reset, so a reset
    // mid-transaction never resumes in the middle of a frame.
    cs_rise     = cs_s & ~cs_q & armed;
    cs_fall     = ~cs_s & cs_q;
    rx_byte     = {rx_sr, mosi_s};
    byte_done   = (state != IDLE) && sample_edge && (bit_cnt == 3'd7) && !cs_fall && !cs_rise;
    mem_we      = byte_done && (state == WDATA) && wel;
  end

  assign active = (state != IDLE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      warm      <= '0;
      armed     <= 1'b0;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      ptr       <= '0;
      op_read   <= 1'b0;
      wrote     <= 1'b0;
      miso      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cmd_err   <= 1'b0;
      wel       <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
      warm      <= {warm[0], 1'b1};
      armed     <= armed | (warm[1] & ~cs_s);
      wr_stb    <= 1'b0;
      cmd_err   <= 1'b0;
      if (!cs_s) begin
        cpol_r <= cpol_i;
        cpha_r <= cpha_i;
      end

      if (cs_fall) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_sr   <= '0;
        miso    <= 1'b0;
        wrote   <= 1'b0;
        if (wrote) wel <= 1'b0;
      end else if (cs_rise) begin
        state   <= INSTR;
        bit_cnt <= '0;
        tx_sr   <= '0;
        miso    <= 1'b0;
        wrote   <= 1'b0;
      end else if (state != IDLE) begin
        if (sample_edge) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (shift_edge) begin
          miso  <= tx_sr[7] & ((state == RDATA) || (state == STAT));
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
        // Byte boundaries land on sample edges, so the reload never collides with a shift.
        if (byte_done) begin
          tx_sr <= '0;
          case (state)
            INSTR: begin
              case (rx_byte)
                8'h06: begin wel <= 1'b1; state <= IGNORE; end
                8'h04: begin wel <= 1'b0; state <= IGNORE; end
                8'h02, 8'h03: begin op_read <= rx_byte[0]; state <= ADDR1; end
                8'h05: begin tx_sr <= {6'b0, wel, 1'b0}; state <= STAT; end
                default: begin cmd_err <= 1'b1; state <= IGNORE; end
              endcase
            end
            ADDR1: state <= ADDR2;
            ADDR2: state <= ADDR3;
            ADDR3: begin
              if (op_read) begin
                tx_sr <= mem[rx_byte[MEM_AW-1:0]];
                ptr   <= rx_byte[MEM_AW-1:0] + 1'b1;
                state <= RDATA;
              end else begin
                ptr   <= rx_byte[MEM_AW-1:0];
                state <= WDATA;
              end
            end
            WDATA: begin
              if (wel) begin
                wr_stb  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= rx_byte;
                ptr     <= ptr + 1'b1;
                wrote   <= 1'b1;
              end
            end
            RDATA: begin
              tx_sr <= mem[ptr];
              ptr   <= ptr + 1'b1;
            end
            STAT:    tx_sr <= {6'b0, wel, 1'b0};
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= rx_byte;
  end

endmodule
